// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared constants and state encoding for the RV32M multiply/divide unit
package muldiv_pkg;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

    localparam int ITERATIONS = 32;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_div_op(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - shared 64-bit accumulator doing one shift-add or restoring-subtract step per cycle
module muldiv_iter
    import muldiv_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        enable,
    input  logic        is_div,
    input  logic [31:0] a_mag,
    input  logic [31:0] b_mag,
    output logic [63:0] acc_next,
    output logic        last
);

    logic [63:0] acc;
    logic [31:0] opnd;
    logic [4:0]  count;
    logic        div_q;
    logic [32:0] sum;
    logic [32:0] trial;

    // Multiply: low half holds the multiplier, shifted out LSB-first.
    // Divide: low half holds the dividend, quotient bits shift in from the right.
    always_comb begin
        sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        trial = acc[63:31] - {1'b0, opnd};
        if (div_q) begin
            if (!trial[32]) acc_next = {trial[31:0], acc[30:0], 1'b1};
            else            acc_next = {acc[62:0], 1'b0};
        end else begin
            acc_next = {sum, acc[31:1]};
        end
    end

    assign last = (count == 5'(ITERATIONS - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            acc   <= '0;
            opnd  <= '0;
            count <= '0;
            div_q <= 1'b0;
        end else if (load) begin
            div_q <= is_div;
            acc   <= {32'd0, is_div ? a_mag : b_mag};
            opnd  <= is_div ? b_mag : a_mag;
            count <= '0;
        end else if (enable) begin
            acc   <= acc_next;
            count <= count + 5'd1;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle RV32M multiply/divide unit with fast path for divide corner cases
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] data_rs1,
    input  logic [XLEN-1:0] data_rs2,
    input  logic [4:0]      addr_rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      addr_rd_out
);

    state_t      state_q, state_d;
    logic [2:0]  funct3_q;
    logic        neg_q;
    logic [4:0]  rd_q;
    logic        load, enable, last;
    logic [63:0] acc_next;

    logic        a_neg, b_neg, neg_start;
    logic [31:0] a_mag, b_mag;
    logic        div_zero, overflow, fast;
    logic [31:0] fast_result;
    logic [63:0] prod;
    logic [31:0] div_sel, calc_result;

    // Operands are reduced to magnitudes; the sign is reapplied on the way out.
    always_comb begin
        a_neg     = (funct3 inside {MUL, MULH, MULHSU, DIV, REM}) && data_rs1[31];
        b_neg     = (funct3 inside {MUL, MULH, DIV, REM}) && data_rs2[31];
        a_mag     = a_neg ? -data_rs1 : data_rs1;
        b_mag     = b_neg ? -data_rs2 : data_rs2;
        neg_start = (is_div_op(funct3) && funct3[1]) ? a_neg : (a_neg ^ b_neg);

        div_zero  = is_div_op(funct3) && (data_rs2 == '0);
        overflow  = (funct3 == DIV || funct3 == REM) && (data_rs1 == INT_MIN) && (data_rs2 == '1);
        fast      = div_zero || overflow;
        if (div_zero) fast_result = funct3[1] ? data_rs1 : DIV0_QUOT;
        else          fast_result = funct3[1] ? 32'd0 : INT_MIN;
    end

    always_comb begin
        prod    = neg_q ? -acc_next : acc_next;
        div_sel = funct3_q[1] ? acc_next[63:32] : acc_next[31:0];
        if (is_div_op(funct3_q))  calc_result = neg_q ? -div_sel : div_sel;
        else if (funct3_q == MUL) calc_result = prod[31:0];
        else                      calc_result = prod[63:32];
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        enable  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = fast ? DONE : CALC;
                end
            end
            CALC: begin
                enable = 1'b1;
                if (last) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    muldiv_iter u_iter (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .enable   (enable),
        .is_div   (is_div_op(funct3)),
        .a_mag    (a_mag),
        .b_mag    (b_mag),
        .acc_next (acc_next),
        .last     (last)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            funct3_q    <= '0;
            neg_q       <= 1'b0;
            rd_q        <= '0;
            result      <= '0;
            addr_rd_out <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                funct3_q <= funct3;
                neg_q    <= neg_start;
                rd_q     <= addr_rd_in;
                if (fast) begin
                    result      <= fast_result;
                    addr_rd_out <= addr_rd_in;
                end
            end
            // result/rd only change when an operation completes
            if (state_q == CALC && last) begin
                result      <= calc_result;
                addr_rd_out <= rd_q;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clock = 1'b0;
    logic        reset, start;
    logic [2:0]  funct3;
    logic [31:0] data_rs1, data_rs2;
    logic [4:0]  addr_rd_in;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  addr_rd_out;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .funct3      (funct3),
        .data_rs1    (data_rs1),
        .data_rs2    (data_rs2),
        .addr_rd_in  (addr_rd_in),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .addr_rd_out (addr_rd_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Issues one request, scrambles the inputs afterwards, then measures latency and busy time.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_res, input int exp_lat);
        int lat;
        int busy_cnt;
        @(negedge clock);
        funct3 = f3; data_rs1 = a; data_rs2 = b; addr_rd_in = rd; start = 1'b1;
        @(negedge clock);
        start = 1'b0; funct3 = ~f3; data_rs1 = ~a; data_rs2 = ~b; addr_rd_in = ~rd;
        lat = 1;
        busy_cnt = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            @(negedge clock);
            lat++;
        end
        if (busy) busy_cnt++;
        check({tag, "_result"},  result, exp_res);
        check({tag, "_rd"},      32'(addr_rd_out), 32'(rd));
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy"},    32'(busy_cnt), 32'(exp_lat));
        @(negedge clock);
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_idle"},       {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int  lat;
        bit  saw_done;
        reset = 1'b1; start = 1'b0; funct3 = '0;
        data_rs1 = '0; data_rs2 = '0; addr_rd_in = '0;
        repeat (3) @(negedge clock);
        check("reset_busy",   {31'd0, busy}, 32'd0);
        check("reset_done",   {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_rd",     32'(addr_rd_out), 32'd0);
        reset = 1'b0;

        run_op("mul",    MUL,    32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 33);
        run_op("mulh",   MULH,   32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000, 33);
        run_op("mulhu",  MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 33);
        run_op("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF, 33);
        run_op("div",    DIV,    32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFD, 33);
        run_op("rem",    REM,    32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFF, 33);
        run_op("divu",   DIVU,   32'd100,       32'd7,         5'd8,  32'd14,        33);
        run_op("remu",   REMU,   32'd100,       32'd7,         5'd9,  32'd2,         33);
        run_op("div0",   DIV,    32'd5,         32'd0,         5'd10, 32'hFFFF_FFFF, 1);
        run_op("remu0",  REMU,   32'd5,         32'd0,         5'd11, 32'd5,         1);
        run_op("divovf", DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1);
        run_op("removf", REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0,         1);

        // start pulses in CALC and in DONE must be ignored
        @(negedge clock);
        funct3 = MUL; data_rs1 = 32'd3; data_rs2 = 32'd5; addr_rd_in = 5'd14; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("hold_result", result, 32'd0);
        check("hold_rd",     32'(addr_rd_out), 32'd13);
        repeat (4) @(negedge clock);
        funct3 = DIVU; data_rs1 = 32'd9; data_rs2 = 32'd0; addr_rd_in = 5'd20; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        lat = 6;
        while (!done && lat < 100) begin
            @(negedge clock);
            lat++;
        end
        check("ign_latency", 32'(lat), 32'd33);
        funct3 = DIVU; data_rs1 = 32'd9; data_rs2 = 32'd0; addr_rd_in = 5'd21; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("ign_done_busy", {31'd0, busy}, 32'd0);
        check("ign_result",    result, 32'd15);
        check("ign_rd",        32'(addr_rd_out), 32'd14);

        // reset after iteration 10 aborts with no done
        @(negedge clock);
        funct3 = MULHU; data_rs1 = 32'h1234_5678; data_rs2 = 32'h9ABC_DEF0; addr_rd_in = 5'd22; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check("abort_busy",   {31'd0, busy}, 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_rd",     32'(addr_rd_out), 32'd0);
        reset = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", {31'd0, saw_done}, 32'd0);

        run_op("post_mulhu", MULHU, 32'h89AB_CDEF, 32'h0000_0100, 5'd5, 32'h0000_0089, 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
